// File: rtl/ysyx_lsu_axi_bridge_pkg.sv
// Shared types and constants for the LSU-to-AXI4-Lite data bridge.
package ysyx_lsu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] SZ_B = 4'h1;
  localparam logic [3:0] SZ_H = 4'h3;
  localparam logic [3:0] SZ_W = 4'hf;

  // Anything that is not a byte or half mask is handled as a word.
  function automatic logic [3:0] norm_size(input logic [7:0] m);
    case (m)
      8'h01:   return SZ_B;
      8'h03:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_axi_bridge_if.sv
// LSU-side request bundle and AXI4-Lite data port bundle.
interface ysyx_lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic [7:0]        lsu_rstrb;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_awvalid;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wstrb;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic              lsu_fault;

  modport master (
    output lsu_araddr, lsu_arvalid, lsu_rstrb,
    output lsu_awaddr, lsu_awvalid, lsu_wdata,
    output lsu_wstrb, lsu_wvalid,
    input  lsu_rdata, lsu_rvalid, lsu_wready,
    input  lsu_fault
  );

  modport slave (
    input  lsu_araddr, lsu_arvalid, lsu_rstrb,
    input  lsu_awaddr, lsu_awvalid, lsu_wdata,
    input  lsu_wstrb, lsu_wvalid,
    output lsu_rdata, lsu_rvalid, lsu_wready,
    output lsu_fault
  );
endinterface

interface ysyx_axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  modport master (
    output m_araddr, m_arvalid, m_rready,
    output m_awaddr, m_awvalid, m_wdata,
    output m_wstrb, m_wvalid, m_bready,
    input  m_arready, m_rdata, m_rresp,
    input  m_rvalid, m_awready, m_wready,
    input  m_bresp, m_bvalid
  );

  modport slave (
    input  m_araddr, m_arvalid, m_rready,
    input  m_awaddr, m_awvalid, m_wdata,
    input  m_wstrb, m_wvalid, m_bready,
    output m_arready, m_rdata, m_rresp,
    output m_rvalid, m_awready, m_wready,
    output m_bresp, m_bvalid
  );
endinterface

// File: rtl/ysyx_lsu_lane_align.sv
// Byte-lane shifter: store data/strobe left, load data right,
// plus the misaligned-access check.
module ysyx_lsu_lane_align
  import ysyx_lsu_axi_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        off_i,
  input  logic [3:0]        size_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misaligned_o
);

  logic [4:0] sh;

  assign sh      = {off_i, 3'b000};
  assign wdata_o = wdata_i << sh;
  assign wstrb_o = size_i << off_i;
  assign rdata_o = rdata_i >> sh;

  always_comb begin
    misaligned_o = 1'b0;
    unique case (1'b1)
      (size_i == SZ_H): misaligned_o = (off_i == 2'd3);
      (size_i == SZ_W): misaligned_o = (off_i != 2'd0);
      default:          misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu_axi_bridge.sv
// LSU load/store to AXI4-Lite master bridge, one access in flight.
module ysyx_lsu_axi_bridge
  import ysyx_lsu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_lsu_req_if.slave         lsu,
  ysyx_axi_lite_if.master       m
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wready_q, wready_d;
  logic              fault_q, fault_d;

  logic              st_req;
  logic [3:0]        size_sel;
  logic [1:0]        off_sel;
  logic [DATA_W-1:0] al_wdata;
  logic [3:0]        al_wstrb;
  logic [DATA_W-1:0] al_rdata;
  logic              mis;
  logic              aw_hs, w_hs;
  logic              aw_fin, w_fin;

  assign st_req = lsu.lsu_awvalid & lsu.lsu_wvalid;

  // In IDLE the aligner looks at the incoming request;
  // afterwards it uses the latched offset for read data.
  always_comb begin
    if (st_req) begin
      size_sel = norm_size(lsu.lsu_wstrb);
    end else begin
      size_sel = norm_size(lsu.lsu_rstrb);
    end
    if (state_q != S_IDLE) begin
      off_sel = addr_q[1:0];
    end else if (st_req) begin
      off_sel = lsu.lsu_awaddr[1:0];
    end else begin
      off_sel = lsu.lsu_araddr[1:0];
    end
  end

  ysyx_lsu_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .off_i       (off_sel),
    .size_i      (size_sel),
    .wdata_i     (lsu.lsu_wdata),
    .rdata_i     (m.m_rdata),
    .wdata_o     (al_wdata),
    .wstrb_o     (al_wstrb),
    .rdata_o     (al_rdata),
    .misaligned_o(mis)
  );

  assign aw_hs  = awvalid_q & m.m_awready;
  assign w_hs   = wvalid_q & m.m_wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    wready_d  = 1'b0;
    fault_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (st_req) begin
          addr_d = lsu.lsu_awaddr;
          if (mis) begin
            wready_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            wdata_d   = al_wdata;
            wstrb_d   = al_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end
        end else if (lsu.lsu_arvalid) begin
          addr_d = lsu.lsu_araddr;
          if (mis) begin
            rdata_d  = '0;
            rvalid_d = 1'b1;
            fault_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (m.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m.m_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = al_rdata;
          rvalid_d = 1'b1;
          fault_d  = (m.m_rresp != RESP_OKAY);
          state_d  = S_DONE;
        end
      end
      S_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m.m_bvalid) begin
          bready_d = 1'b0;
          wready_d = 1'b1;
          fault_d  = (m.m_bresp != RESP_OKAY);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      wready_q  <= wready_d;
      fault_q   <= fault_d;
    end
  end

  assign m.m_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign m.m_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign m.m_arvalid = arvalid_q;
  assign m.m_rready  = rready_q;
  assign m.m_awvalid = awvalid_q;
  assign m.m_wvalid  = wvalid_q;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = wstrb_q;
  assign m.m_bready  = bready_q;

  assign lsu.lsu_rdata  = rdata_q;
  assign lsu.lsu_rvalid = rvalid_q;
  assign lsu.lsu_wready = wready_q;
  assign lsu.lsu_fault  = fault_q;

endmodule
